noc_local_ni: RTL and testbench
===============================

NOC_LOCAL_NI -- requirements
Module: noc_local_ni

Interface
REQ-001 The block SHALL have parameter XCOORD, default 1, meaning this tile's X coordinate (4 bits used).
REQ-002 The block SHALL have parameter YCOORD, default 1, meaning this tile's Y coordinate (4 bits used).
REQ-003 The block SHALL have parameter CREDITS, default 4, meaning the router local input-buffer depth (1..15).
REQ-004 The block SHALL have parameter RX_DEPTH, default 4, meaning the local receive FIFO depth (power of two, 2..16).
REQ-005 The block SHALL have these ports (name  direction  width  meaning); clock and reset are decided: one clock; reset is synchronous and active-low.
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous active-low reset.
- tx_data_o  out  16  flit to router local input.
- tx_enable_o  out  1  flit valid strobe, one cycle per flit.
- tx_credit_i  in  1  one credit returned by router per pulse.
- rx_data_i  in  16  flit from router local output.
- rx_enable_i  in  1  flit valid strobe.
- rx_credit_o  out  1  one credit returned to router per pulse.
- send_valid_i  in  1  client send request.
- send_ready_o  out  1  NI can accept a flit.
- send_dest_x_i  in  4  destination X.
- send_dest_y_i  in  4  destination Y.
- send_payload_i  in  8  payload.
- recv_valid_o  out  1  RX FIFO non-empty.
- recv_payload_o  out  8  head flit payload.
- recv_ready_i  in  1  client consumes head flit.
- credit_cnt_o  out  4  current TX credits.
- err_o  out  3  sticky {misroute, rx_overflow, credit_overflow}.

Function
REQ-006 The flit format SHALL be [15:8] payload, [7:4] dest X, [3:0] dest Y.
REQ-007 send_ready_o SHALL be combinational (credit_cnt != 0) and SHALL NOT depend on send_valid_i.
REQ-008 A send SHALL be accepted on a cycle with send_valid_i && send_ready_o; tx_data_o/tx_enable_o SHALL be registered, asserted exactly the following cycle for one cycle.
REQ-009 tx_enable_o SHALL be 0 on any cycle without an accept in the previous cycle; tx_data_o SHALL hold its last value.
REQ-010 The credit counter SHALL decrement on accept, increment on tx_credit_i, and be unchanged when both occur in the same cycle.
REQ-011 An increment that would exceed CREDITS SHALL saturate at CREDITS and set err_o[0].
REQ-012 rx_enable_i SHALL write rx_data_i into the RX FIFO in the same cycle; recv_valid_o/recv_payload_o SHALL be first-word-fall-through from the FIFO head.
REQ-013 A pop SHALL occur when recv_valid_o && recv_ready_i; rx_credit_o SHALL pulse high for exactly one cycle, the cycle after each pop.
REQ-014 A write while full with no simultaneous pop SHALL be dropped and set err_o[1]; a write while full with a simultaneous pop SHALL be accepted.
REQ-015 A write to an empty FIFO with a simultaneous pop request SHALL NOT pop (recv_valid_o is 0 that cycle).
REQ-016 A received flit whose [7:4]/[3:0] differ from XCOORD/YCOORD SHALL set err_o[2] and still be stored and delivered normally.
REQ-017 err_o bits SHALL be sticky until reset.

Reset
REQ-018 When rst is low at a clock edge, the block SHALL set credit_cnt = CREDITS, empty the FIFO, drive tx_enable_o=0, tx_data_o=0, rx_credit_o=0 and err_o=0, and discard any pending TX flit.
REQ-019 Reset asserted mid-operation SHALL take effect at that edge with no partial flit emitted; the first accept SHALL be possible on the first cycle after release.

Structure
REQ-020 Package noc_pkg SHALL hold FLIT_W=16, COORD_W=4, a packed struct flit_t {payload, dest_x, dest_y}, and the err bit index constants.
REQ-021 The RX buffer SHALL be a sub-module ni_rx_fifo (depth RX_DEPTH, count-based full/empty); TX credit logic SHALL stay in noc_local_ni.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- Reset, then send 4 flits back-to-back with no credits returned -> 4 tx_enable_o pulses on cycles 1-4, send_ready_o=0 after the 4th accept, credit_cnt_o=0.
- At credit_cnt=0, pulse tx_credit_i -> send_ready_o=1 next cycle; a simultaneous accept and credit holds the count at 1.
- A 5th tx_credit_i pulse with count already 4 -> count stays 4, err_o=3'b001.
- Send dest (2,3), payload 0xA5 -> tx_data_o=16'hA523 exactly one cycle after the accept.
- Write 4 RX flits with recv_ready_i=0, then a 5th -> err_o[1]=1 and the FIFO still holds the first 4 in order; pop all -> 4 rx_credit_o pulses, each one cycle after its pop.
- RX flit 16'h7712 at XCOORD=1, YCOORD=1 -> err_o[2]=1, payload 0x77 delivered; assert rst mid-stream -> all outputs reset, recv_valid_o=0.

Source files
------------

// File: rtl/noc_pkg.sv
// ---------------------------------------------------------------------------
// noc_pkg
// Shared definitions for the local network interface slice.
//   FLIT_W / COORD_W / PAYLOAD_W : flit and coordinate field widths
//   flit_t                       : packed flit {payload, dest_x, dest_y}
//   ERR_*                        : bit positions inside the sticky err vector
//   make_flit()                  : assembles a flit from its three fields
// ---------------------------------------------------------------------------
package noc_pkg;

  localparam int FLIT_W    = 16;
  localparam int COORD_W   = 4;
  localparam int PAYLOAD_W = FLIT_W - 2 * COORD_W;

  // Bit positions in the sticky error vector.
  localparam int ERR_W          = 3;
  localparam int ERR_CREDIT_OVF = 0;
  localparam int ERR_RX_OVF     = 1;
  localparam int ERR_MISROUTE   = 2;

  typedef struct packed {
    logic [PAYLOAD_W-1:0] payload;
    logic [COORD_W-1:0]   dest_x;
    logic [COORD_W-1:0]   dest_y;
  } flit_t;

  function automatic flit_t make_flit(input logic [PAYLOAD_W-1:0] payload,
                                      input logic [COORD_W-1:0]   dest_x,
                                      input logic [COORD_W-1:0]   dest_y);
    flit_t f;
    f.payload = payload;
    f.dest_x  = dest_x;
    f.dest_y  = dest_y;
    return f;
  endfunction

endpackage

// File: rtl/ni_rx_fifo.sv
// ---------------------------------------------------------------------------
// ni_rx_fifo
// First-word-fall-through receive buffer with count-based full/empty.
// Ports:
//   clk, rst      : clock, synchronous active-low reset
//   wr_en, wr_data: write strobe and data (written at the same edge)
//   rd_req        : consumer wants the head entry
//   rd_valid      : buffer non-empty, rd_data shows the head entry
//   pop           : head entry is removed at this edge
//   drop          : write lost because the buffer is full and nothing pops
// A write while full is still accepted when a pop happens in the same cycle;
// a read request while empty never pops, even if a write arrives.
// ---------------------------------------------------------------------------
module ni_rx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_req,
  output logic             rd_valid,
  output logic [WIDTH-1:0] rd_data,
  output logic             pop,
  output logic             drop
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             full;
  logic             push;

  assign full     = (count == CW'(DEPTH));
  assign rd_valid = (count != '0);
  assign pop      = rd_req && rd_valid;
  // When full, a same-cycle pop frees the slot the write lands in.
  assign push     = wr_en && (!full || pop);
  assign drop     = wr_en && full && !pop;
  assign rd_data  = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; validity is tracked by count alone.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/noc_local_ni.sv
// ---------------------------------------------------------------------------
// noc_local_ni
// Local network interface between a tile client and its router port.
// TX: client flits go to the router under credit flow control.
// RX: router flits are buffered and returned as credits when consumed.
// Ports:
//   clk, rst                      : clock, synchronous active-low reset
//   tx_data_o, tx_enable_o        : registered flit + one-cycle strobe to router
//   tx_credit_i                   : one credit back from router per pulse
//   rx_data_i, rx_enable_i        : flit + strobe from router
//   rx_credit_o                   : one credit to router, cycle after each pop
//   send_valid_i / send_ready_o   : client send handshake
//   send_dest_x_i/_y_i/payload_i  : flit fields for the send
//   recv_valid_o / recv_payload_o : head of receive buffer (fall-through)
//   recv_ready_i                  : client consumes the head flit
//   credit_cnt_o                  : current TX credits
//   err_o                         : sticky {misroute, rx_overflow, credit_overflow}
// ---------------------------------------------------------------------------
module noc_local_ni
  import noc_pkg::*;
#(
  parameter int XCOORD   = 1,
  parameter int YCOORD   = 1,
  parameter int CREDITS  = 4,
  parameter int RX_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic [FLIT_W-1:0]    tx_data_o,
  output logic                 tx_enable_o,
  input  logic                 tx_credit_i,
  input  logic [FLIT_W-1:0]    rx_data_i,
  input  logic                 rx_enable_i,
  output logic                 rx_credit_o,
  input  logic                 send_valid_i,
  output logic                 send_ready_o,
  input  logic [COORD_W-1:0]   send_dest_x_i,
  input  logic [COORD_W-1:0]   send_dest_y_i,
  input  logic [PAYLOAD_W-1:0] send_payload_i,
  output logic                 recv_valid_o,
  output logic [PAYLOAD_W-1:0] recv_payload_o,
  input  logic                 recv_ready_i,
  output logic [3:0]           credit_cnt_o,
  output logic [ERR_W-1:0]     err_o
);

  localparam logic [3:0]         CREDIT_MAX = 4'(CREDITS);
  localparam logic [COORD_W-1:0] MY_X       = COORD_W'(XCOORD);
  localparam logic [COORD_W-1:0] MY_Y       = COORD_W'(YCOORD);

  logic [3:0]       credit_cnt;
  logic [3:0]       credit_next;
  logic             credit_ovf;
  logic             accept;
  flit_t            tx_flit;
  flit_t            rx_flit;
  logic             misroute;
  logic             rx_pop;
  logic             rx_drop;
  logic [ERR_W-1:0] err_set;

  // ---------------- TX side ----------------
  assign send_ready_o = (credit_cnt != '0);
  assign accept       = send_valid_i && send_ready_o;
  assign tx_flit      = make_flit(send_payload_i, send_dest_x_i, send_dest_y_i);
  assign credit_cnt_o = credit_cnt;

  // A simultaneous accept and returned credit cancel out. A credit returned
  // while already at the maximum means the router over-returned: saturate
  // and flag it.
  always_comb begin
    credit_next = credit_cnt;
    credit_ovf  = 1'b0;
    case ({accept, tx_credit_i})
      2'b10: credit_next = credit_cnt - 4'd1;
      2'b01: begin
        if (credit_cnt == CREDIT_MAX) credit_ovf = 1'b1;
        else                          credit_next = credit_cnt + 4'd1;
      end
      default: credit_next = credit_cnt;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      credit_cnt  <= CREDIT_MAX;
      tx_enable_o <= 1'b0;
      tx_data_o   <= '0;
    end else begin
      credit_cnt  <= credit_next;
      tx_enable_o <= accept;
      if (accept) tx_data_o <= tx_flit;
    end
  end

  // ---------------- RX side ----------------
  // The routing fields are only needed for the misroute check at ingress,
  // so the buffer stores the payload alone.
  assign rx_flit  = flit_t'(rx_data_i);
  assign misroute = rx_enable_i && ((rx_flit.dest_x != MY_X) || (rx_flit.dest_y != MY_Y));

  ni_rx_fifo #(
    .DEPTH (RX_DEPTH),
    .WIDTH (PAYLOAD_W)
  ) u_rx_fifo (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (rx_enable_i),
    .wr_data  (rx_flit.payload),
    .rd_req   (recv_ready_i),
    .rd_valid (recv_valid_o),
    .rd_data  (recv_payload_o),
    .pop      (rx_pop),
    .drop     (rx_drop)
  );

  // ---------------- credits back and sticky errors ----------------
  always_comb begin
    err_set                 = '0;
    err_set[ERR_CREDIT_OVF] = credit_ovf;
    err_set[ERR_RX_OVF]     = rx_drop;
    err_set[ERR_MISROUTE]   = misroute;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_credit_o <= 1'b0;
      err_o       <= '0;
    end else begin
      rx_credit_o <= rx_pop;
      err_o       <= err_o | err_set;
    end
  end

endmodule

// File: tb/tb_noc_local_ni.sv
// ---------------------------------------------------------------------------
// tb_noc_local_ni
// Directed stimulus for noc_local_ni. A negedge monitor keeps a reference
// model (credits, TX scoreboard queue, RX queue, sticky errors) and compares
// every output each cycle; the stimulus block adds spot checks with fixed
// expected constants at the interesting points.
// ---------------------------------------------------------------------------
module tb_noc_local_ni;

  localparam int XCOORD   = 1;
  localparam int YCOORD   = 1;
  localparam int CREDITS  = 4;
  localparam int RX_DEPTH = 4;

  logic        clk;
  logic        rst;
  logic [15:0] tx_data_o;
  logic        tx_enable_o;
  logic        tx_credit_i;
  logic [15:0] rx_data_i;
  logic        rx_enable_i;
  logic        rx_credit_o;
  logic        send_valid_i;
  logic        send_ready_o;
  logic [3:0]  send_dest_x_i;
  logic [3:0]  send_dest_y_i;
  logic [7:0]  send_payload_i;
  logic        recv_valid_o;
  logic [7:0]  recv_payload_o;
  logic        recv_ready_i;
  logic [3:0]  credit_cnt_o;
  logic [2:0]  err_o;

  int testsRun    = 0;
  int testsFailed = 0;

  // Reference model state (advanced by the monitor only)
  logic [15:0] txq[$];
  logic [7:0]  rxq[$];
  int          modelCredits = CREDITS;
  logic        expTxEnable  = 1'b0;
  logic [15:0] expTxData    = 16'h0000;
  logic        expRxCredit  = 1'b0;
  logic [2:0]  modelErr     = 3'b000;

  noc_local_ni #(
    .XCOORD   (XCOORD),
    .YCOORD   (YCOORD),
    .CREDITS  (CREDITS),
    .RX_DEPTH (RX_DEPTH)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .tx_data_o      (tx_data_o),
    .tx_enable_o    (tx_enable_o),
    .tx_credit_i    (tx_credit_i),
    .rx_data_i      (rx_data_i),
    .rx_enable_i    (rx_enable_i),
    .rx_credit_o    (rx_credit_o),
    .send_valid_i   (send_valid_i),
    .send_ready_o   (send_ready_o),
    .send_dest_x_i  (send_dest_x_i),
    .send_dest_y_i  (send_dest_y_i),
    .send_payload_i (send_payload_i),
    .recv_valid_o   (recv_valid_o),
    .recv_payload_o (recv_payload_o),
    .recv_ready_i   (recv_ready_i),
    .credit_cnt_o   (credit_cnt_o),
    .err_o          (err_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    testsRun++;
    assert (observed === expected) else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Advance n clock edges; inputs change 1 time unit after the edge.
  task automatic applyStimulus(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic setSend(input logic v, input logic [3:0] x, input logic [3:0] y,
                         input logic [7:0] p);
    send_valid_i   = v;
    send_dest_x_i  = x;
    send_dest_y_i  = y;
    send_payload_i = p;
  endtask

  // Monitor: compare outputs against the model, then advance the model with
  // the inputs the coming rising edge will sample.
  always @(negedge clk) begin
    logic [15:0] expFlit;
    logic [7:0]  dummy;
    logic        accept;
    logic        pop;
    logic        full;

    checkOutput("tx_enable", 16'(tx_enable_o), 16'(expTxEnable));
    if (tx_enable_o === 1'b1) begin
      expFlit = (txq.size() != 0) ? txq.pop_front() : 16'hxxxx;
      checkOutput("tx_data_scoreboard", tx_data_o, expFlit);
    end else begin
      checkOutput("tx_data_hold", tx_data_o, expTxData);
    end
    checkOutput("credit_cnt", 16'(credit_cnt_o), 16'(modelCredits));
    checkOutput("send_ready", 16'(send_ready_o), 16'(modelCredits != 0));
    checkOutput("err", 16'(err_o), 16'(modelErr));
    checkOutput("recv_valid", 16'(recv_valid_o), 16'(rxq.size() != 0));
    if (rxq.size() != 0) checkOutput("recv_payload", 16'(recv_payload_o), 16'(rxq[0]));
    checkOutput("rx_credit", 16'(rx_credit_o), 16'(expRxCredit));

    if (!rst) begin
      modelCredits = CREDITS;
      expTxEnable  = 1'b0;
      expTxData    = 16'h0000;
      expRxCredit  = 1'b0;
      modelErr     = 3'b000;
      txq.delete();
      rxq.delete();
    end else begin
      accept      = send_valid_i && (modelCredits != 0);
      expTxEnable = accept;
      if (accept) begin
        expTxData = {send_payload_i, send_dest_x_i, send_dest_y_i};
        txq.push_back(expTxData);
      end
      if (accept && !tx_credit_i) modelCredits--;
      else if (!accept && tx_credit_i) begin
        if (modelCredits == CREDITS) modelErr[0] = 1'b1;
        else modelCredits++;
      end

      full = (rxq.size() == RX_DEPTH);
      pop  = recv_ready_i && (rxq.size() != 0);
      if (pop) dummy = rxq.pop_front();
      if (rx_enable_i) begin
        if (full && !pop) modelErr[1] = 1'b1;
        else rxq.push_back(rx_data_i[15:8]);
        if (rx_data_i[7:4] != 4'(XCOORD) || rx_data_i[3:0] != 4'(YCOORD))
          modelErr[2] = 1'b1;
      end
      expRxCredit = pop;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not reach the end of stimulus");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    rst          = 1'b0;
    tx_credit_i  = 1'b0;
    rx_data_i    = 16'h0000;
    rx_enable_i  = 1'b0;
    recv_ready_i = 1'b0;
    setSend(1'b0, 4'h0, 4'h0, 8'h00);
    applyStimulus(3);
    rst = 1'b1;

    // Reset state
    @(negedge clk);
    checkOutput("reset_credit_cnt", 16'(credit_cnt_o), 16'd4);
    checkOutput("reset_tx_enable", 16'(tx_enable_o), 16'd0);
    checkOutput("reset_tx_data", tx_data_o, 16'h0000);
    checkOutput("reset_err", 16'(err_o), 16'd0);
    checkOutput("reset_recv_valid", 16'(recv_valid_o), 16'd0);
    checkOutput("reset_send_ready", 16'(send_ready_o), 16'd1);

    // Four back-to-back sends with no credits returned
    applyStimulus(1);
    for (int i = 0; i < 4; i++) begin
      setSend(1'b1, 4'(i), 4'(i + 1), 8'h10 + 8'(i));
      applyStimulus(1);
    end
    setSend(1'b1, 4'h9, 4'h9, 8'hEE);
    @(negedge clk);
    checkOutput("burst_last_flit", tx_data_o, 16'h1334);
    checkOutput("burst_credit_zero", 16'(credit_cnt_o), 16'd0);
    checkOutput("burst_ready_low", 16'(send_ready_o), 16'd0);
    applyStimulus(1);
    setSend(1'b0, 4'h0, 4'h0, 8'h00);
    @(negedge clk);
    checkOutput("blocked_no_tx", 16'(tx_enable_o), 16'd0);

    // One credit back, then simultaneous accept + credit
    tx_credit_i = 1'b1;
    applyStimulus(1);
    tx_credit_i = 1'b0;
    @(negedge clk);
    checkOutput("credit_back_ready", 16'(send_ready_o), 16'd1);
    checkOutput("credit_back_cnt", 16'(credit_cnt_o), 16'd1);
    tx_credit_i = 1'b1;
    setSend(1'b1, 4'h2, 4'h3, 8'hA5);
    applyStimulus(1);
    tx_credit_i = 1'b0;
    setSend(1'b0, 4'h0, 4'h0, 8'h00);
    @(negedge clk);
    checkOutput("simul_credit_cnt", 16'(credit_cnt_o), 16'd1);
    checkOutput("a523_enable", 16'(tx_enable_o), 16'd1);
    checkOutput("a523_data", tx_data_o, 16'hA523);
    applyStimulus(1);
    @(negedge clk);
    checkOutput("a523_enable_drop", 16'(tx_enable_o), 16'd0);
    checkOutput("a523_data_hold", tx_data_o, 16'hA523);

    // Refill to 4, then one credit too many
    tx_credit_i = 1'b1;
    applyStimulus(3);
    @(negedge clk);
    checkOutput("refill_cnt", 16'(credit_cnt_o), 16'd4);
    checkOutput("refill_no_err", 16'(err_o), 16'd0);
    applyStimulus(1);
    tx_credit_i = 1'b0;
    @(negedge clk);
    checkOutput("ovf_cnt_saturated", 16'(credit_cnt_o), 16'd4);
    checkOutput("ovf_err", 16'(err_o), 16'b001);

    // Fill RX buffer, then one write too many
    rx_enable_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      rx_data_i = {8'h31 + 8'(i), 4'h1, 4'h1};
      applyStimulus(1);
    end
    rx_enable_i = 1'b0;
    @(negedge clk);
    checkOutput("rx_full_err", 16'(err_o), 16'b011);
    checkOutput("rx_full_head", 16'(recv_payload_o), 16'h0031);

    // Write while full with a simultaneous pop is accepted, then drain
    recv_ready_i = 1'b1;
    rx_enable_i  = 1'b1;
    rx_data_i    = 16'h3611;
    applyStimulus(1);
    rx_enable_i  = 1'b0;
    @(negedge clk);
    checkOutput("full_pop_write_head", 16'(recv_payload_o), 16'h0032);
    checkOutput("full_pop_write_err", 16'(err_o), 16'b011);
    applyStimulus(4);
    recv_ready_i = 1'b0;
    @(negedge clk);
    checkOutput("drained_empty", 16'(recv_valid_o), 16'd0);
    checkOutput("drained_last_credit", 16'(rx_credit_o), 16'd1);
    applyStimulus(1);
    @(negedge clk);
    checkOutput("credit_one_cycle", 16'(rx_credit_o), 16'd0);

    // Write to empty with a pop request does not pop that cycle
    rx_enable_i  = 1'b1;
    recv_ready_i = 1'b1;
    rx_data_i    = 16'h4411;
    applyStimulus(1);
    rx_enable_i  = 1'b0;
    @(negedge clk);
    checkOutput("empty_write_kept", 16'(recv_payload_o), 16'h0044);
    checkOutput("empty_write_no_credit", 16'(rx_credit_o), 16'd0);
    applyStimulus(1);
    recv_ready_i = 1'b0;
    @(negedge clk);
    checkOutput("empty_write_popped", 16'(rx_credit_o), 16'd1);

    // Misrouted flit is flagged but delivered
    rx_enable_i = 1'b1;
    rx_data_i   = 16'h7712;
    applyStimulus(1);
    rx_enable_i = 1'b0;
    @(negedge clk);
    checkOutput("misroute_err", 16'(err_o), 16'b111);
    checkOutput("misroute_payload", 16'(recv_payload_o), 16'h0077);

    // Reset in the middle of traffic
    setSend(1'b1, 4'h1, 4'h1, 8'h55);
    rx_enable_i = 1'b1;
    rx_data_i   = 16'h5511;
    rst         = 1'b0;
    applyStimulus(1);
    setSend(1'b0, 4'h0, 4'h0, 8'h00);
    rx_enable_i = 1'b0;
    @(negedge clk);
    checkOutput("midrst_tx_enable", 16'(tx_enable_o), 16'd0);
    checkOutput("midrst_tx_data", tx_data_o, 16'h0000);
    checkOutput("midrst_cnt", 16'(credit_cnt_o), 16'd4);
    checkOutput("midrst_err", 16'(err_o), 16'd0);
    checkOutput("midrst_recv_valid", 16'(recv_valid_o), 16'd0);
    checkOutput("midrst_rx_credit", 16'(rx_credit_o), 16'd0);

    // First accept possible right after release
    rst = 1'b1;
    setSend(1'b1, 4'h4, 4'h5, 8'h66);
    applyStimulus(1);
    setSend(1'b0, 4'h0, 4'h0, 8'h00);
    @(negedge clk);
    checkOutput("post_rst_tx_enable", 16'(tx_enable_o), 16'd1);
    checkOutput("post_rst_tx_data", tx_data_o, 16'h6645);
    checkOutput("post_rst_cnt", 16'(credit_cnt_o), 16'd3);

    applyStimulus(2);
    @(negedge clk);
    checkOutput("tx_queue_drained", 16'(txq.size()), 16'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
